// File: rtl/register_file_mp_pkg.sv
// regfile_pkg: shared defaults, clear FSM states and write-priority select
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 32;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

    // {take port 2, take port 1}; port 2 wins when both hit the same entry
    function automatic logic [1:0] rf_sel_wr(input logic i_hit1, input logic i_hit2);
        return {i_hit2, i_hit1 & ~i_hit2};
    endfunction

endpackage

// File: rtl/register_file_mp_clear_ctrl.sv
// rf_clear_ctrl: sweep sequencer that zeroes every entry after reset or on request
module rf_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear_req,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    rf_state_e     r_state, w_state_nxt;
    logic [AW-1:0] r_cnt, w_cnt_nxt;

    // state and sweep pointer; reset always restarts the sweep from entry 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RF_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // one entry per cycle while clearing; requests during a sweep are ignored
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_busy      = (r_state == RF_CLEAR);
        o_clr_we    = o_busy;
        o_clr_addr  = r_cnt;
        case (r_state)
            RF_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == AW'(DEPTH - 1)) w_state_nxt = RF_READY;
            end
            RF_READY: begin
                if (i_clear_req) begin
                    w_state_nxt = RF_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = RF_CLEAR;
        endcase
    end

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read, dual-write register file with bypass, zero register and hardware clear
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN      = XLEN_DEF,
    parameter int  DEPTH     = DEPTH_DEF,
    parameter int  NUM_RD    = 2,
    parameter int  BYPASS_EN = 1,
    parameter int  ZERO_REG  = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                   Clk_Core,
    input  logic                   Rst_Core_N,
    input  logic [NUM_RD*AW-1:0]   Read_Addr,
    output logic [NUM_RD*XLEN-1:0] Read_Data,
    input  logic [AW-1:0]          Write_Addr_Port_1,
    input  logic [XLEN-1:0]        Write_Data_Port_1,
    input  logic                   Wr_En_1,
    input  logic [AW-1:0]          Write_Addr_Port_2,
    input  logic [XLEN-1:0]        Write_Data_Port_2,
    input  logic                   Wr_En_2,
    input  logic                   Clear_Req,
    output logic                   Busy,
    output logic                   Wr_Drop
);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic            r_wr_drop;
    logic            w_busy, w_clr_we, w_we1, w_we2;
    logic [AW-1:0]   w_clr_addr;
    logic [1:0]      w_sel [DEPTH];

    rf_clear_ctrl #(.DEPTH(DEPTH), .AW(AW)) u_clr (
        .i_clk       (Clk_Core),
        .i_rst_n     (Rst_Core_N),
        .i_clear_req (Clear_Req),
        .o_busy      (w_busy),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr)
    );

    // effective enables: no writes during a sweep, entry 0 is read-only when hardwired
    assign w_we1 = Wr_En_1 && !w_busy && !(ZERO_REG != 0 && Write_Addr_Port_1 == '0);
    assign w_we2 = Wr_En_2 && !w_busy && !(ZERO_REG != 0 && Write_Addr_Port_2 == '0);

    // per-entry decode of which write port lands this cycle
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            w_sel[i] = rf_sel_wr(w_we1 && Write_Addr_Port_1 == AW'(i), w_we2 && Write_Addr_Port_2 == AW'(i));
    end

    // storage: sweep zeroes, otherwise the prioritised write port updates
    always_ff @(posedge Clk_Core) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_clr_we && w_clr_addr == AW'(i)) r_mem[i] <= '0;
            else if (w_sel[i][1]) r_mem[i] <= Write_Data_Port_2;
            else if (w_sel[i][0]) r_mem[i] <= Write_Data_Port_1;
        end
    end

    // flag any write attempt discarded because a sweep was running
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) r_wr_drop <= 1'b0;
        else r_wr_drop <= w_busy && (Wr_En_1 || Wr_En_2);
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic [1:0]    w_hit;
        assign w_addr = Read_Addr[k*AW +: AW];
        assign w_hit  = rf_sel_wr(BYPASS_EN != 0 && w_we1 && Write_Addr_Port_1 == w_addr,
                                  BYPASS_EN != 0 && w_we2 && Write_Addr_Port_2 == w_addr);
        assign Read_Data[k*XLEN +: XLEN] = (w_busy || (ZERO_REG != 0 && w_addr == '0)) ? '0 :
                                           w_hit[1] ? Write_Data_Port_2 :
                                           w_hit[0] ? Write_Data_Port_1 : r_mem[w_addr];
    end

    assign Busy    = w_busy;
    assign Wr_Drop = r_wr_drop;

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: scoreboard bench for register_file_mp with and without bypass
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  ra;
    logic [63:0] rda, rdb;
    logic [4:0]  wa1, wa2;
    logic [31:0] wd1, wd2;
    logic        we1, we2, clr;
    logic        busy_a, busy_b, drop_a, drop_b;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    register_file_mp dut_a (
        .Clk_Core(clk), .Rst_Core_N(rst_n), .Read_Addr(ra), .Read_Data(rda),
        .Write_Addr_Port_1(wa1), .Write_Data_Port_1(wd1), .Wr_En_1(we1),
        .Write_Addr_Port_2(wa2), .Write_Data_Port_2(wd2), .Wr_En_2(we2),
        .Clear_Req(clr), .Busy(busy_a), .Wr_Drop(drop_a)
    );

    register_file_mp #(.BYPASS_EN(0)) dut_b (
        .Clk_Core(clk), .Rst_Core_N(rst_n), .Read_Addr(ra), .Read_Data(rdb),
        .Write_Addr_Port_1(wa1), .Write_Data_Port_1(wd1), .Wr_En_1(we1),
        .Write_Addr_Port_2(wa2), .Write_Data_Port_2(wd2), .Wr_En_2(we2),
        .Clear_Req(clr), .Busy(busy_b), .Wr_Drop(drop_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] e);
        sbq.push_back('{tag, e});
    endtask

    task automatic pop(input logic [31:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow got %h want none", obs);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic idle;
        we1 = 1'b0;
        we2 = 1'b0;
        clr = 1'b0;
    endtask

    task automatic sweep(input string tag, input int exp_n);
        int n = 0;
        push(tag, exp_n);
        while (busy_a && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        pop(n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ra = '0;
        wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0;
        idle();
        repeat (3) @(negedge clk);
        #1;
        push("rst_busy", 1); push("rst_drop", 0); push("rst_rd", 0);
        pop(busy_a); pop(drop_a); pop(rda[31:0]);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sweep("init_sweep", 32);
        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            push("init_rd0", 0); push("init_rd1", 0);
            #1;
            pop(rda[31:0]); pop(rda[63:32]);
        end
        @(negedge clk);
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEADBEEF; ra[4:0] = 5'd5;
        push("byp_same", 32'hDEADBEEF); push("nobyp_same", 0);
        #1;
        pop(rda[31:0]); pop(rdb[31:0]);
        @(negedge clk);
        idle();
        push("byp_next", 32'hDEADBEEF); push("nobyp_next", 32'hDEADBEEF);
        #1;
        pop(rda[31:0]); pop(rdb[31:0]);
        @(negedge clk);
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h11111111;
        we2 = 1'b1; wa2 = 5'd7; wd2 = 32'h22222222; ra[4:0] = 5'd7;
        push("dual_byp", 32'h22222222); push("dual_old", 0);
        #1;
        pop(rda[31:0]); pop(rdb[31:0]);
        @(negedge clk);
        idle();
        push("dual_arr_a", 32'h22222222); push("dual_arr_b", 32'h22222222);
        #1;
        pop(rda[31:0]); pop(rdb[31:0]);
        @(negedge clk);
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hA5A5A5A5;
        we2 = 1'b1; wa2 = 5'd10; wd2 = 32'h5A5A5A5A; ra = {5'd10, 5'd9};
        push("diff_byp1", 32'hA5A5A5A5); push("diff_byp2", 32'h5A5A5A5A);
        #1;
        pop(rda[31:0]); pop(rda[63:32]);
        @(negedge clk);
        idle();
        push("diff_arr1", 32'hA5A5A5A5); push("diff_arr2", 32'h5A5A5A5A);
        #1;
        pop(rdb[31:0]); pop(rdb[63:32]);
        @(negedge clk);
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
        we2 = 1'b1; wa2 = 5'd0; wd2 = 32'hFFFFFFFF; ra = {5'd5, 5'd0};
        push("z_same", 0); push("z_other", 32'hDEADBEEF);
        #1;
        pop(rda[31:0]); pop(rda[63:32]);
        @(negedge clk);
        idle();
        push("z_arr_a", 0); push("z_arr_b", 0); push("z_drop", 0);
        #1;
        pop(rda[31:0]); pop(rdb[31:0]); pop(drop_a);
        @(negedge clk);
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h00001234; clr = 1'b1; ra = {5'd4, 5'd3};
        push("clr_cyc_byp", 32'h00001234); push("clr_cyc_busy", 0);
        #1;
        pop(rda[31:0]); pop(busy_a);
        @(negedge clk);
        idle();
        we2 = 1'b1; wa2 = 5'd4; wd2 = 32'h00005555;
        push("clr_busy", 1); push("clr_rd_zero", 0); push("clr_drop_pre", 0);
        #1;
        pop(busy_a); pop(rda[31:0]); pop(drop_a);
        @(negedge clk);
        idle();
        clr = 1'b1;
        push("drop_pulse", 1);
        #1;
        pop(drop_a);
        @(negedge clk);
        idle();
        push("drop_end", 0);
        #1;
        pop(drop_a);
        sweep("clr_sweep", 30);
        push("clr_a3", 0); push("clr_a4", 0); push("clr_b3", 0); push("clr_b4", 0);
        #1;
        pop(rda[31:0]); pop(rda[63:32]); pop(rdb[31:0]); pop(rdb[63:32]);
        @(negedge clk);
        we1 = 1'b1; wa1 = 5'd12; wd1 = 32'hCAFEF00D; clr = 1'b1; ra = {5'd3, 5'd12};
        @(negedge clk);
        idle();
        for (int i = 1; i < 10; i++) @(negedge clk);
        we1 = 1'b1; wa1 = 5'd13; wd1 = 32'h0000BEEF;
        @(negedge clk);
        idle();
        push("mid_drop", 1);
        #1;
        pop(drop_a);
        rst_n = 1'b0;
        #1;
        push("mid_rst_busy", 1); push("mid_rst_drop", 0); push("mid_rst_rd", 0);
        pop(busy_a); pop(drop_a); pop(rda[31:0]);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        sweep("rst_sweep", 32);
        push("rst_a12", 0); push("rst_b12", 0); push("rst_busy_b", 0);
        #1;
        pop(rda[31:0]); pop(rdb[31:0]); pop(busy_b);
        chk("sb_empty", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the core's general-purpose register file.
- Multi-ported: NUM_RD combinational read ports and two write ports with fixed priority.
- Optional same-cycle write-to-read bypass and a hardwired zero register.
- A hardware clear sequencer zeroes every entry after reset or on request, so no memory-init file is needed. Sits in decode/writeback of the RV32 pipeline; write port 2 is the later commit stage.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- AW, $clog2(DEPTH), address width (derived, not overridden).
- NUM_RD, 2, number of read ports, 1 to 4.
- BYPASS_EN, 1, 1 = a write in the current cycle is visible on reads in the same cycle.
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.

Ports:
- Clk_Core  in  1  core clock, all state on rising edge.
- Rst_Core_N  in  1  asynchronous, active-low reset.
- Read_Addr  in  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- Read_Data  out  NUM_RD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
- Write_Addr_Port_1  in  AW  write port 1 address.
- Write_Data_Port_1  in  XLEN  write port 1 data.
- Wr_En_1  in  1  write port 1 enable.
- Write_Addr_Port_2  in  AW  write port 2 address (priority port).
- Write_Data_Port_2  in  XLEN  write port 2 data.
- Wr_En_2  in  1  write port 2 enable.
- Clear_Req  in  1  single-cycle pulse requesting a full clear.
- Busy  out  1  clear sweep in progress.
- Wr_Drop  out  1  registered; pulses one cycle after a write is discarded.

Behaviour:
- Reset (asynchronous, active-low): state=CLEAR, clear counter=0, Busy=1, Wr_Drop=0.
  - Array contents are not reset; they are overwritten by the sweep.
- FSM states CLEAR and READY.
  - CLEAR: each cycle writes 0 to entry[cnt], cnt++. When cnt==DEPTH-1 the last entry is written and the next state is READY.
  - Busy stays high for exactly DEPTH cycles after reset release.
  - READY: Clear_Req=1 moves to CLEAR next cycle with cnt=0.
  - Clear_Req while in CLEAR is ignored; the sweep does not restart.
- Reset asserted mid-sweep: immediate return to CLEAR with cnt=0. The sweep restarts from entry 0 after release.
- Writes (READY only):
  - Entry updates on the rising edge when Wr_En_x=1.
  - Both ports enabled with the same address: port 2 data is stored.
  - Different addresses: both entries are stored in the same cycle.
  - ZERO_REG=1: writes to address 0 are silently discarded. This is not a drop, so Wr_Drop is not raised.
- Writes while Busy=1: discarded. Wr_Drop=1 on the next cycle if Wr_En_1 or Wr_En_2 was high.
- The Clear_Req cycle itself (still READY): the writes in that cycle commit. The sweep then overwrites them.
- Reads: combinational, zero latency.
  - Read_Data=0 while Busy=1.
  - ZERO_REG=1 and address 0: output is 0 regardless of bypass.
  - BYPASS_EN=1 and READY: if the address matches an enabled write this cycle, the write data is returned, with port 2 taking priority over port 1. Otherwise the array value is returned.
  - BYPASS_EN=0: the array value is returned, so a new value is visible the cycle after the write.
- Addresses of DEPTH or more cannot occur because AW is exact.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEF=32 and DEPTH_DEF=32.
  - Enum rf_state_e {RF_CLEAR, RF_READY}.
  - Function rf_sel_wr (write-priority/bypass select) shared by the write path and the read path.
- Sub-module rf_clear_ctrl:
  - Contains the FSM and the AW-bit counter.
  - Outputs Busy, clr_we and clr_addr; the top level muxes these into the array write port.

Test Plan:
- Reset release, DEPTH=32: Busy=1 for exactly 32 cycles, then 0. All 32 entries read 0 afterwards.
- READY, Wr_En_1=1, addr 5, data 0xDEADBEEF, read port 0 addr 5:
  - BYPASS_EN=1: 0xDEADBEEF in the same cycle.
  - BYPASS_EN=0: old value this cycle, 0xDEADBEEF next cycle.
- Both write ports to addr 7, port1=0x11111111, port2=0x22222222: bypass read and the later array read both return 0x22222222.
- ZERO_REG=1, write 0xFFFFFFFF to addr 0: reads of addr 0 return 0 in the same and later cycles; Wr_Drop stays 0.
- Write 0x1234 to addr 3, pulse Clear_Req, write addr 4 during Busy:
  - Wr_Drop pulses one cycle later.
  - After 32 cycles, addr 3 and addr 4 both read 0.
- Assert Rst_Core_N low at sweep cycle 10 for 2 cycles: Busy=1 immediately. After release Busy lasts a full 32 cycles and all entries end at 0.
